telemetry_framer: RTL and testbench

- Periodic telemetry packetizer feeding the cell-phone UART transmitter.
- Snapshots speed, heart rate, heart-rate cap, pitch, assist level and phase-wire ADC at a fixed rate.
- Serializes the snapshot as an 11-byte checksummed frame through a byte-level valid/ready handshake.
- Sits between the sensor/motor-control outputs and the UART tx byte interface.

---
 rtl/telemetry_pkg.sv | 34 +++
 rtl/rate_tick.sv | 38 +++
 rtl/telemetry_framer.sv | 139 +++++++++++++
 tb/tb_telemetry_framer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/telemetry_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : telemetry_pkg
//  Description : Shared types and frame layout constants for the telemetry
//                framer.
//  Revision    : 1.0 - initial release
// ============================================================================
package telemetry_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } frame_state_t;

  localparam int         FRAME_LEN    = 11;
  localparam logic [7:0] PAYLOAD_LEN  = 8'h08;
  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

  // Byte positions inside a frame
  localparam logic [3:0] IDX_SYNC     = 4'd0;
  localparam logic [3:0] IDX_LEN      = 4'd1;
  localparam logic [3:0] IDX_SPEED    = 4'd2;
  localparam logic [3:0] IDX_HR       = 4'd3;
  localparam logic [3:0] IDX_CAP      = 4'd4;
  localparam logic [3:0] IDX_PITCH_HI = 4'd5;
  localparam logic [3:0] IDX_PITCH_LO = 4'd6;
  localparam logic [3:0] IDX_ASSIST   = 4'd7;
  localparam logic [3:0] IDX_ADC_HI   = 4'd8;
  localparam logic [3:0] IDX_ADC_LO   = 4'd9;
  localparam logic [3:0] IDX_CSUM     = 4'(FRAME_LEN - 1);

endpackage
`default_nettype wire

// File: rtl/rate_tick.sv
`default_nettype none
// ============================================================================
//  Module      : rate_tick
//  Description : Free-running period counter producing a one-cycle tick every
//                PERIOD cycles while enabled; held at zero when disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module rate_tick #(
  parameter int PERIOD = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int             CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0]  LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  // Count 0..PERIOD-1 while enabled, wrap on the tick, park at zero otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/telemetry_framer.sv
`default_nettype none
// ============================================================================
//  Module      : telemetry_framer
//  Description : Periodically snapshots sensor/motor fields and serializes
//                them as an 11-byte checksummed frame over a byte-wide
//                valid/ready handshake toward the UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module telemetry_framer
  import telemetry_pkg::*;
#(
  parameter int         CLK_HZ    = 50_000_000,
  parameter int         FRAME_HZ  = 10,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC
) (
  input  logic        c50m,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  speed,
  input  logic [7:0]  heart_rate,
  input  logic [7:0]  heart_cap,
  input  logic [9:0]  pitch,
  input  logic [7:0]  assist,
  input  logic [11:0] adc_phase,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        frame_busy,
  output logic [7:0]  overrun_count
);

  // Frame period in clocks; expected to be at least 64
  localparam int PERIOD = CLK_HZ / FRAME_HZ;

  logic tick;

  rate_tick #(.PERIOD(PERIOD)) u_rate_tick (
    .clk    (c50m),
    .rst    (reset),
    .enable (enable),
    .tick   (tick)
  );

  frame_state_t state;
  logic [3:0]   idx;        // index of the byte currently on byte_out
  logic [7:0]   sum;        // running sum of accepted bytes 1..idx-1
  logic [7:0]   snap_speed, snap_hr, snap_cap, snap_assist;
  logic [9:0]   snap_pitch;
  logic [11:0]  snap_adc;

  logic [3:0]   sel;
  logic [7:0]   sum_next;
  logic [7:0]   mux_byte;

  // Select the next byte to present; the checksum folds in the byte being
  // accepted this cycle so byte 10 is ready right after byte 9 is taken
  always_comb begin
    sum_next = sum;
    if (idx != IDX_SYNC) begin
      sum_next = sum + byte_out;
    end
    sel = (state == SEND) ? (idx + 4'd1) : IDX_SYNC;
    case (sel)
      IDX_SYNC:     mux_byte = SYNC_BYTE;
      IDX_LEN:      mux_byte = PAYLOAD_LEN;
      IDX_SPEED:    mux_byte = snap_speed;
      IDX_HR:       mux_byte = snap_hr;
      IDX_CAP:      mux_byte = snap_cap;
      IDX_PITCH_HI: mux_byte = {6'b0, snap_pitch[9:8]};
      IDX_PITCH_LO: mux_byte = snap_pitch[7:0];
      IDX_ASSIST:   mux_byte = snap_assist;
      IDX_ADC_HI:   mux_byte = {4'b0, snap_adc[11:8]};
      IDX_ADC_LO:   mux_byte = snap_adc[7:0];
      IDX_CSUM:     mux_byte = 8'd0 - sum_next;
      default:      mux_byte = 8'd0;
    endcase
  end

  // Frame FSM: snapshot on tick, present bytes under handshake, count drops
  always_ff @(posedge c50m or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= 4'd0;
      sum           <= 8'd0;
      byte_out      <= 8'd0;
      byte_valid    <= 1'b0;
      frame_busy    <= 1'b0;
      overrun_count <= 8'd0;
      snap_speed    <= 8'd0;
      snap_hr       <= 8'd0;
      snap_cap      <= 8'd0;
      snap_pitch    <= 10'd0;
      snap_assist   <= 8'd0;
      snap_adc      <= 12'd0;
    end else begin
      if (tick && (state != IDLE) && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            snap_speed  <= speed;
            snap_hr     <= heart_rate;
            snap_cap    <= heart_cap;
            snap_pitch  <= pitch;
            snap_assist <= assist;
            snap_adc    <= adc_phase;
            sum         <= 8'd0;
            idx         <= 4'd0;
            frame_busy  <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          byte_out   <= mux_byte;
          byte_valid <= 1'b1;
          idx        <= IDX_SYNC;
          state      <= SEND;
        end
        SEND: begin
          if (byte_valid && byte_ready) begin
            sum <= sum_next;
            if (idx == IDX_CSUM) begin
              byte_valid <= 1'b0;
              frame_busy <= 1'b0;
              state      <= IDLE;
            end else begin
              idx      <= idx + 4'd1;
              byte_out <= mux_byte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_telemetry_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_telemetry_framer
//  Description : Directed self-checking bench for telemetry_framer with a
//                100-cycle frame period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_telemetry_framer;

  logic        c50m = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  speed = 8'h32;
  logic [7:0]  heart_rate = 8'h48;
  logic [7:0]  heart_cap = 8'hC8;
  logic [9:0]  pitch = 10'h12C;
  logic [7:0]  assist = 8'h10;
  logic [11:0] adc_phase = 12'h7FF;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        frame_busy;
  logic [7:0]  overrun_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  int abort_at = 99;
  int snap_at = 99;

  logic [7:0] golden [11] = '{8'hA5, 8'h08, 8'h32, 8'h48, 8'hC8, 8'h01,
                              8'h2C, 8'h10, 8'h07, 8'hFF, 8'h73};
  logic [7:0] got [11];

  telemetry_framer #(
    .CLK_HZ   (100),
    .FRAME_HZ (1),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .c50m         (c50m),
    .reset        (reset),
    .enable       (enable),
    .speed        (speed),
    .heart_rate   (heart_rate),
    .heart_cap    (heart_cap),
    .pitch        (pitch),
    .assist       (assist),
    .adc_phase    (adc_phase),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .frame_busy   (frame_busy),
    .overrun_count(overrun_count)
  );

  always #5 c50m = ~c50m;
  always @(posedge c50m) cyc <= cyc + 1;

  task automatic do_reset();
    @(negedge c50m);
    reset = 1'b1;
    enable = 1'b0;
    byte_ready = 1'b0;
    repeat (3) @(negedge c50m);
    reset = 1'b0;
  endtask

  // Count negedges until byte_valid is seen (bounded)
  task automatic wait_valid(output int n);
    n = 0;
    while (!byte_valid && n < 1000) begin
      @(negedge c50m);
      n++;
    end
  endtask

  // Drive byte_ready with the given duty (percent) and capture accepted bytes;
  // checks byte_out stability across stalls
  task automatic collect(input int duty);
    int idx = 0;
    int budget = 0;
    logic stalled = 1'b0;
    logic [7:0] prev = 8'h00;
    for (int i = 0; i < 11; i++) got[i] = 8'hXX;
    while (idx < 11 && idx != abort_at && budget < 5000) begin
      if (idx == snap_at) speed = 8'hFF;
      byte_ready = ($urandom_range(0, 99) < duty);
      #1;
      if (byte_valid) begin
        if (idx == 0 && !stalled && budget == 0) start_cyc = cyc;
        if (stalled) begin
          vectors++;
          if (byte_out !== prev) begin
            miscompares++;
            $display("FAIL stall_stable idx%0d: byte_out %02h, held value %02h", idx, byte_out, prev);
          end
        end
        if (byte_ready) begin
          got[idx] = byte_out;
          idx++;
        end
        stalled = !byte_ready;
        prev = byte_out;
      end
      @(negedge c50m);
      budget++;
    end
    if (budget >= 5000) begin
      vectors++;
      miscompares++;
      $display("FAIL collect_timeout: bytes %0d, needed 11", idx);
    end
  endtask

  task automatic test_reset();
    vectors += 4;
    if (byte_out !== 8'h00) begin miscompares++; $display("FAIL reset_byte_out: %02h expected 00", byte_out); end
    if (byte_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: %b expected 0", byte_valid); end
    if (frame_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: %b expected 0", frame_busy); end
    if (overrun_count !== 8'h00) begin miscompares++; $display("FAIL reset_overrun: %02h expected 00", overrun_count); end
  endtask

  task automatic test_single_frame();
    int n;
    int first;
    do_reset();
    enable = 1'b1;
    wait_valid(n);
    vectors += 2;
    if (n != 101) begin miscompares++; $display("FAIL first_latency: %0d cycles expected 101", n); end
    if (frame_busy !== 1'b1) begin miscompares++; $display("FAIL busy_in_frame: %b expected 1", frame_busy); end
    collect(100);
    first = start_cyc;
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (got[i] !== golden[i]) begin
        miscompares++;
        $display("FAIL single_byte%0d: got %02h expected %02h", i, got[i], golden[i]);
      end
    end
    vectors += 2;
    if (byte_valid !== 1'b0) begin miscompares++; $display("FAIL end_valid: %b expected 0", byte_valid); end
    if (frame_busy !== 1'b0) begin miscompares++; $display("FAIL end_busy: %b expected 0", frame_busy); end
    wait_valid(n);
    collect(100);
    vectors++;
    if (start_cyc - first != 100) begin
      miscompares++;
      $display("FAIL frame_spacing: %0d cycles expected 100", start_cyc - first);
    end
  endtask

  task automatic test_backpressure();
    int n;
    wait_valid(n);
    collect(30);
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (got[i] !== golden[i]) begin
        miscompares++;
        $display("FAIL bp_byte%0d: got %02h expected %02h", i, got[i], golden[i]);
      end
    end
  endtask

  task automatic test_snapshot();
    int n;
    logic [7:0] exp_ff [11];
    logic [7:0] s;
    for (int i = 0; i < 11; i++) exp_ff[i] = golden[i];
    exp_ff[2] = 8'hFF;
    s = 8'h00;
    for (int i = 1; i < 10; i++) s = s + exp_ff[i];
    exp_ff[10] = 8'h00 - s;
    wait_valid(n);
    snap_at = 3;
    collect(100);
    snap_at = 99;
    vectors += 2;
    if (got[2] !== 8'h32) begin miscompares++; $display("FAIL snap_isolated: got %02h expected 32", got[2]); end
    if (got[10] !== 8'h73) begin miscompares++; $display("FAIL snap_csum: got %02h expected 73", got[10]); end
    wait_valid(n);
    collect(100);
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (got[i] !== exp_ff[i]) begin
        miscompares++;
        $display("FAIL snap_next_byte%0d: got %02h expected %02h", i, got[i], exp_ff[i]);
      end
    end
    speed = 8'h32;
  endtask

  task automatic test_overrun();
    int n;
    do_reset();
    enable = 1'b1;
    wait_valid(n);
    byte_ready = 1'b0;
    repeat (250) @(negedge c50m);
    vectors++;
    if (overrun_count !== 8'd2) begin miscompares++; $display("FAIL overrun_two: %0d expected 2", overrun_count); end
    collect(100);
    vectors += 2;
    if (got[0] !== 8'hA5) begin miscompares++; $display("FAIL overrun_sync: got %02h expected a5", got[0]); end
    if (got[10] !== 8'h73) begin miscompares++; $display("FAIL overrun_csum: got %02h expected 73", got[10]); end
    wait_valid(n);
    byte_ready = 1'b0;
    repeat (30000) @(negedge c50m);
    vectors++;
    if (overrun_count !== 8'hFF) begin miscompares++; $display("FAIL overrun_sat: %0d expected 255", overrun_count); end
    collect(100);
    vectors++;
    if (overrun_count !== 8'hFF) begin miscompares++; $display("FAIL overrun_hold: %0d expected 255", overrun_count); end
  endtask

  task automatic test_enable_reset();
    int n;
    int seen;
    do_reset();
    enable = 1'b1;
    wait_valid(n);
    enable = 1'b0;
    collect(100);
    vectors += 2;
    if (got[0] !== 8'hA5) begin miscompares++; $display("FAIL en_sync: got %02h expected a5", got[0]); end
    if (got[10] !== 8'h73) begin miscompares++; $display("FAIL en_csum: got %02h expected 73", got[10]); end
    seen = 0;
    repeat (300) begin
      @(negedge c50m);
      if (byte_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL en_quiet: %0d valid cycles expected 0", seen); end

    do_reset();
    enable = 1'b1;
    wait_valid(n);
    abort_at = 5;
    collect(100);
    abort_at = 99;
    vectors++;
    if (byte_out !== 8'h01) begin miscompares++; $display("FAIL pre_reset_byte5: got %02h expected 01", byte_out); end
    reset = 1'b1;
    #1;
    vectors += 4;
    if (byte_out !== 8'h00) begin miscompares++; $display("FAIL async_byte_out: %02h expected 00", byte_out); end
    if (byte_valid !== 1'b0) begin miscompares++; $display("FAIL async_valid: %b expected 0", byte_valid); end
    if (frame_busy !== 1'b0) begin miscompares++; $display("FAIL async_busy: %b expected 0", frame_busy); end
    if (overrun_count !== 8'h00) begin miscompares++; $display("FAIL async_overrun: %02h expected 00", overrun_count); end
    @(negedge c50m);
    reset = 1'b0;
    byte_ready = 1'b1;
    wait_valid(n);
    vectors += 2;
    if (n != 101) begin miscompares++; $display("FAIL post_reset_latency: %0d cycles expected 101", n); end
    if (byte_out !== 8'hA5) begin miscompares++; $display("FAIL post_reset_first: %02h expected a5", byte_out); end
  endtask

  initial begin
    repeat (3) @(negedge c50m);
    test_reset();
    test_single_frame();
    test_backpressure();
    test_snapshot();
    test_overrun();
    test_enable_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
